dec_blck_gatherer: RTL and testbench

- Upstream neighbour of the decryption digest formatter.
- Collects BUS_SIZE-wide ciphertext words from the input bus into one BLCK_SIZE feed block, plus a per-byte mask.
- blck_out drives the formatter's feed_blck_in. blck_validity drives its dig_blck_in_validity: bit=1 means the byte carries no ciphertext, so the digest byte is kept.
- Single-block buffer with valid/ready handshake on both sides; handles partial final words and partial final blocks.

---
 rtl/spook_dec_pkg.sv | 19 +
 rtl/dec_word_byte_mask.sv | 50 +++++
 rtl/dec_blck_gatherer.sv | 146 ++++++++++++++
 tb/tb_dec_blck_gatherer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spook_dec_pkg.sv
// Shared constants and state encoding for the decryption-side block gatherer.
// Default geometry: 256-bit feed block assembled from 32-bit bus words.
package spook_dec_pkg;

    localparam int unsigned DEF_BLCK_SIZE  = 256;
    localparam int unsigned DEF_BUS_SIZE   = 32;
    localparam int unsigned BLCKdiv8       = DEF_BLCK_SIZE / 8;
    localparam int unsigned WORDS_PER_BLCK = DEF_BLCK_SIZE / DEF_BUS_SIZE;
    localparam int unsigned BYTES_PER_WORD = DEF_BUS_SIZE / 8;

    // Padding marker written after the last ciphertext byte when padding is built in
    localparam logic [7:0]  PAD_BYTE       = 8'h01;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } gather_state_t;

endpackage

// File: rtl/dec_word_byte_mask.sv
// Combinational byte masking of one bus word.
// Keeps bytes 0..n-1 of a last word (n clamped to the word width), zeroes the
// rest and flags them in inv_c (1 = byte carries no ciphertext). A non-last word
// passes through fully valid.
// Build option: DEC_GATHER_PAD_EN writes PAD_BYTE into the first invalid byte.
// Ports:
//   data   - incoming bus word, byte j at [j*8 +: 8]
//   n      - valid byte count, only meaningful when last=1
//   last   - word is the final word of the message
//   word_c - masked word
//   inv_c  - per-byte invalid flags
module dec_word_byte_mask
    import spook_dec_pkg::*;
#(
    parameter int unsigned BUS_SIZE = DEF_BUS_SIZE
) (
    input  logic [BUS_SIZE-1:0]              data,
    input  logic [$clog2(BUS_SIZE/8+1)-1:0]  n,
    input  logic                             last,
    output logic [BUS_SIZE-1:0]              word_c,
    output logic [BUS_SIZE/8-1:0]            inv_c
);

    localparam int unsigned WORD_BYTES = BUS_SIZE / 8;
    localparam int unsigned NB_W       = $clog2(WORD_BYTES + 1);

    logic [NB_W-1:0] n_eff;

    // Clamp the byte count and build the masked word
    always_comb begin
        n_eff  = NB_W'(WORD_BYTES);
        word_c = '0;
        inv_c  = '1;
        if (last && (n < NB_W'(WORD_BYTES))) begin
            n_eff = n;
        end
        for (int unsigned j = 0; j < WORD_BYTES; j++) begin
            if (NB_W'(j) < n_eff) begin
                word_c[j*8 +: 8] = data[j*8 +: 8];
                inv_c[j]         = 1'b0;
            end
`ifdef DEC_GATHER_PAD_EN
            else if (NB_W'(j) == n_eff) begin
                word_c[j*8 +: 8] = PAD_BYTE;
            end
`endif
        end
    end

endmodule

// File: rtl/dec_blck_gatherer.sv
// Gathers BUS_SIZE ciphertext words into one BLCK_SIZE feed block plus a
// per-byte invalid mask for the decryption digest formatter. Single block
// buffer: FILL accepts words, FULL holds the block until the consumer takes it.
// Build option: DEC_GATHER_PAD_EN inserts PAD_BYTE at the first invalid byte
// after the message end (validity bit of that byte stays 1).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   clear           - synchronous flush of any partial or held block
//   data_in*        - input word stream (valid/ready, last, byte count)
//   blck_out        - assembled block, word k at [k*BUS_SIZE +: BUS_SIZE]
//   blck_validity   - bit i=1: byte i holds no ciphertext
//   blck_last       - block contains the final message byte
//   blck_valid/ready- output handshake
module dec_blck_gatherer
    import spook_dec_pkg::*;
#(
    parameter int unsigned BLCK_SIZE = DEF_BLCK_SIZE,
    parameter int unsigned BUS_SIZE  = DEF_BUS_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [BUS_SIZE-1:0]              data_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    input  logic                             data_in_last,
    input  logic [$clog2(BUS_SIZE/8+1)-1:0]  data_in_bytes,
    output logic [BLCK_SIZE-1:0]             blck_out,
    output logic [BLCK_SIZE/8-1:0]           blck_validity,
    output logic                             blck_last,
    output logic                             blck_valid,
    input  logic                             blck_ready
);

    localparam int unsigned WORD_BYTES = BUS_SIZE / 8;
    localparam int unsigned N_WORDS    = BLCK_SIZE / BUS_SIZE;
    localparam int unsigned BLK_BYTES  = BLCK_SIZE / 8;
    localparam int unsigned CNT_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    gather_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BLCK_SIZE-1:0]   blck_q, blck_d;
    logic [BLK_BYTES-1:0]   inv_q, inv_d;
    logic                   last_q, last_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;

    logic [BUS_SIZE-1:0]    word_c;
    logic [WORD_BYTES-1:0]  inv_c;
    logic [31:0]            slot_bit;
    logic [31:0]            slot_byte;

    dec_word_byte_mask #(
        .BUS_SIZE (BUS_SIZE)
    ) u_mask (
        .data   (data_in),
        .n      (data_in_bytes),
        .last   (data_in_last),
        .word_c (word_c),
        .inv_c  (inv_c)
    );

    // Next-state, slot write and flush logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blck_d    = blck_q;
        inv_d     = inv_q;
        last_d    = last_q;
        slot_bit  = 32'(cnt_q) * BUS_SIZE;
        slot_byte = 32'(cnt_q) * WORD_BYTES;

        if (clear) begin
            state_d = FILL;
            cnt_d   = '0;
            blck_d  = '0;
            inv_d   = '1;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    // ready_q gates the very first cycle after reset release
                    if (data_in_valid && ready_q) begin
                        blck_d[slot_bit +: BUS_SIZE]    = word_c;
                        inv_d[slot_byte +: WORD_BYTES] = inv_c;
                        last_d = data_in_last;
                        cnt_d  = CNT_W'(cnt_q + 1'b1);
`ifdef DEC_GATHER_PAD_EN
                        // Full last word: pad lands on byte 0 of the next slot, if any
                        if (data_in_last && (inv_c == '0) &&
                            (cnt_q != CNT_W'(N_WORDS - 1))) begin
                            blck_d[slot_bit + BUS_SIZE +: 8] = PAD_BYTE;
                        end
`endif
                        if (data_in_last || (cnt_q == CNT_W'(N_WORDS - 1))) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (blck_ready) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        blck_d  = '0;
                        inv_d   = '1;
                        last_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end

        ready_d = (state_d == FILL);
        valid_d = (state_d == FULL);
    end

    // State and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            blck_q  <= '0;
            inv_q   <= '1;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blck_q  <= blck_d;
            inv_q   <= inv_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign data_in_ready = ready_q;
    assign blck_out      = blck_q;
    assign blck_validity = inv_q;
    assign blck_last     = last_q;
    assign blck_valid    = valid_q;

endmodule

// File: tb/tb_dec_blck_gatherer.sv
// Self-checking bench for dec_blck_gatherer: a reference model assembles the
// expected block as words are sent and pushes it to a scoreboard queue; each
// emitted block is popped and compared.
module tb_dec_blck_gatherer;
    import spook_dec_pkg::*;

    localparam int unsigned BW   = DEF_BUS_SIZE;
    localparam int unsigned BL   = DEF_BLCK_SIZE;
    localparam int unsigned NW   = WORDS_PER_BLCK;
    localparam int unsigned BPW  = BYTES_PER_WORD;
    localparam int unsigned NBY  = BLCKdiv8;
    localparam int unsigned NB_W = $clog2(BPW + 1);

    typedef struct {
        logic [BL-1:0]  data;
        logic [NBY-1:0] inv;
        logic           last;
    } blk_t;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic [BW-1:0]   data_in;
    logic            data_in_valid;
    logic            data_in_ready;
    logic            data_in_last;
    logic [NB_W-1:0] data_in_bytes;
    logic [BL-1:0]   blck_out;
    logic [NBY-1:0]  blck_validity;
    logic            blck_last;
    logic            blck_valid;
    logic            blck_ready;

    blk_t            sb[$];
    logic [BL-1:0]   m_data;
    logic [NBY-1:0]  m_inv;
    int              m_cnt;
    int              checks;
    int              errors;

    dec_blck_gatherer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_in_last  (data_in_last),
        .data_in_bytes (data_in_bytes),
        .blck_out      (blck_out),
        .blck_validity (blck_validity),
        .blck_last     (blck_last),
        .blck_valid    (blck_valid),
        .blck_ready    (blck_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_data = '0;
        m_inv  = '1;
        m_cnt  = 0;
    endtask

    // Reference model of one accepted word
    task automatic model_word(input logic [BW-1:0] d, input bit last, input int bytes);
        int   n;
        blk_t e;
        n = last ? ((bytes > int'(BPW)) ? int'(BPW) : bytes) : int'(BPW);
        for (int j = 0; j < n; j++) begin
            m_data[(m_cnt*BPW + j)*8 +: 8] = d[j*8 +: 8];
            m_inv[m_cnt*BPW + j]           = 1'b0;
        end
`ifdef DEC_GATHER_PAD_EN
        if (last) begin
            if (n < int'(BPW))
                m_data[(m_cnt*BPW + n)*8 +: 8] = 8'h01;
            else if (m_cnt < int'(NW) - 1)
                m_data[((m_cnt + 1)*BPW)*8 +: 8] = 8'h01;
        end
`endif
        if (last || m_cnt == int'(NW) - 1) begin
            e.data = m_data;
            e.inv  = m_inv;
            e.last = last;
            sb.push_back(e);
            model_reset();
        end else begin
            m_cnt++;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge
    task automatic send_word(input logic [BW-1:0] d, input bit last, input int bytes);
        int waited = 0;
        data_in       = d;
        data_in_last  = last;
        data_in_bytes = NB_W'(bytes);
        data_in_valid = 1'b1;
        while (!data_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: data_in_ready=%b expected 1 within 50 cycles", data_in_ready);
        end else begin
            model_word(d, last, bytes);
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        data_in_bytes = '0;
    endtask

    // Wait for a block, compare with scoreboard, consume it, check the flush
    task automatic check_block(input string tag, input int max_wait, input bit expect_now);
        int   waited = 0;
        blk_t e;
        while (!blck_valid && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (blck_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: blck_valid=%b expected 1 within %0d cycles", tag, blck_valid, max_wait);
            return;
        end
        if (expect_now) begin
            checks++;
            if (waited != 0) begin
                errors++;
                $display("FAIL %s_latency: valid after %0d extra cycles expected 0", tag, waited);
            end
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: block emitted with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (blck_out !== e.data) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", tag, blck_out, e.data);
        end
        checks++;
        if (blck_validity !== e.inv) begin
            errors++;
            $display("FAIL %s_validity: got %h expected %h", tag, blck_validity, e.inv);
        end
        checks++;
        if (blck_last !== e.last) begin
            errors++;
            $display("FAIL %s_last: got %b expected %b", tag, blck_last, e.last);
        end
        blck_ready = 1'b1;
        @(negedge clk);
        blck_ready = 1'b0;
        checks++;
        if (blck_valid !== 1'b0 || blck_out !== '0 || blck_validity !== '1 || blck_last !== 1'b0) begin
            errors++;
            $display("FAIL %s_flush: valid=%b last=%b validity=%h expected 0/0/all-ones with zero data",
                     tag, blck_valid, blck_last, blck_validity);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (blck_out !== '0 || blck_validity !== '1 || blck_last !== 1'b0 ||
            blck_valid !== 1'b0 || data_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: out_zero=%b validity=%h last=%b valid=%b ready=%b expected 1/all-ones/0/0/0",
                     tag, (blck_out == '0), blck_validity, blck_last, blck_valid, data_in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; clear = 1'b0; data_in = '0; data_in_valid = 1'b0;
        data_in_last = 1'b0; data_in_bytes = '0; blck_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_values");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full block of bytes 0x00..0x1F with last on the final slot
    task automatic test_full_last();
        logic [BW-1:0] w;
        blck_ready = 1'b1;
        for (int k = 0; k < int'(NW); k++) begin
            for (int j = 0; j < int'(BPW); j++) w[j*8 +: 8] = 8'(k*BPW + j);
            send_word(w, k == int'(NW) - 1, BPW);
        end
        checks++;
        if (blck_validity !== '0) begin
            errors++;
            $display("FAIL full_last_validity_const: got %h expected 0", blck_validity);
        end
        check_block("full_last", 5, 1'b1);
    endtask

    // Three words, last carrying two bytes
    task automatic test_partial();
        send_word(32'h1312_1110, 1'b0, 0);
        send_word(32'h2322_2120, 1'b0, 0);
        send_word(32'h3332_3130, 1'b1, 2);
        checks++;
        if (blck_validity !== 32'hFFFF_FC00) begin
            errors++;
            $display("FAIL partial_validity_const: got %h expected ffff_fc00", blck_validity);
        end
        check_block("partial", 5, 1'b1);
    endtask

    // Empty message: last on slot 0 with zero bytes
    task automatic test_empty();
        send_word(32'hDEAD_BEEF, 1'b1, 0);
        checks++;
        if (blck_validity !== '1) begin
            errors++;
            $display("FAIL empty_validity_const: got %h expected all ones", blck_validity);
        end
        check_block("empty", 5, 1'b1);
    endtask

    // Oversized byte count is clamped to the word width
    task automatic test_clamp();
        send_word(32'hA3A2_A1A0, 1'b0, 0);
        send_word(32'hB3B2_B1B0, 1'b0, 0);
        send_word(32'hC3C2_C1C0, 1'b0, 0);
        send_word(32'hD3D2_D1D0, 1'b1, 7);
        checks++;
        if (blck_validity !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL clamp_validity_const: got %h expected ffff_0000", blck_validity);
        end
        check_block("clamp", 5, 1'b1);
    endtask

    // Two full blocks without last; first one held for 5 cycles
    task automatic test_back_to_back();
        logic [BL-1:0]  held;
        logic [NBY-1:0] held_inv;
        blck_ready = 1'b0;
        for (int k = 0; k < int'(NW); k++) send_word(BW'(32'h5000_0000 + $urandom_range(0, 32'h00FF_FFFF)), 1'b0, 0);
        held     = blck_out;
        held_inv = blck_validity;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (data_in_ready !== 1'b0 || blck_valid !== 1'b1 ||
                blck_out !== held || blck_validity !== held_inv) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d ready=%b valid=%b stable=%b expected 0/1/1",
                         c, data_in_ready, blck_valid, (blck_out === held && blck_validity === held_inv));
            end
        end
        check_block("b2b_first", 0, 1'b1);
        for (int k = 0; k < int'(NW); k++) send_word(BW'($urandom), 1'b0, 0);
        check_block("b2b_second", 5, 1'b1);
    endtask

    // clear (with a colliding word) then async reset mid-fill; neither emits a block
    task automatic test_clear_reset();
        for (int k = 0; k < 4; k++) send_word(BW'(32'h7700_0000 + k), 1'b0, 0);
        clear = 1'b1;
        data_in = 32'hFFFF_FFFF;
        data_in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        data_in_valid = 1'b0;
        model_reset();
        checks++;
        if (blck_valid !== 1'b0 || blck_out !== '0 || blck_validity !== '1 || data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_flush: valid=%b validity=%h ready=%b expected 0/all-ones/1",
                     blck_valid, blck_validity, data_in_ready);
        end
        send_word(32'h8811_2233, 1'b0, 0);
        send_word(32'h8844_5566, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (blck_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL no_block_after_reset: valid=%b queue=%0d expected 0/0", blck_valid, sb.size());
        end
        for (int k = 0; k < int'(NW); k++) send_word(BW'(32'h9900_0000 + k), 1'b0, 0);
        check_block("after_reset", 5, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_last();
        test_partial();
        test_empty();
        test_clamp();
        test_back_to_back();
        test_clear_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d blocks left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
